// File: rtl/des_pkg.sv
// Shared DES definitions: permutation index tables, rotation schedule,
// FSM state type, width constants and small helper functions.
// DES_ENCRYPT_MODE_EN: when defined, also provides the left-rotate helper
// used by the encrypt key schedule.
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int HALF_W   = 32;
  localparam int KEY56_W  = 56;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } des_state_e;

  // All tables list DES bit numbers (1 = MSB) in output order.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Per-round rotation amounts, rounds 1..16 at indices 0..15.
  localparam int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // S-box table is 64 nibbles, row-major, first entry in the top nibble.
  // Row = {b[6], b[1]}, column = b[5:2].
  function automatic logic [4:1] sbox_lookup(input logic [255:0] tbl,
                                             input logic [6:1]   b);
    logic [255:0] sh;
    sh = tbl << {b[6], b[1], b[5:2], 2'b00};
    return sh[255:252];
  endfunction

  // Right rotation of a 28-bit key half by 1 or 2 (bit 28 is DES bit 1).
  function automatic logic [28:1] rotr28(input logic [28:1] v, input int n);
    return (n == 2) ? {v[2:1], v[28:3]} : {v[1], v[28:2]};
  endfunction

`ifdef DES_ENCRYPT_MODE_EN
  // Left rotation of a 28-bit key half by 1 or 2.
  function automatic logic [28:1] rotl28(input logic [28:1] v, input int n);
    return (n == 2) ? {v[26:1], v[28:27]} : {v[27:1], v[28]};
  endfunction
`endif

endpackage

// File: rtl/des_f_func.sv
// DES round function f(R, K): E expansion, key mix, S-boxes, P permutation.
// Purely combinational.
module des_f_func
  import des_pkg::*;
(
  input  logic [HALF_W:1]   r,
  input  logic [SUBKEY_W:1] k,
  output logic [HALF_W:1]   f
);

  logic [SUBKEY_W:1] e_r;
  logic [SUBKEY_W:1] x;
  logic [HALF_W:1]   s;

  for (genvar j = 0; j < SUBKEY_W; j++) begin : g_e
    assign e_r[SUBKEY_W-j] = r[HALF_W+1-E_T[j]];
  end

  assign x = e_r ^ k;

  // Slice 1 (bits 48:43) feeds S-box 1, whose output lands in the top nibble.
  sbox1 u_sbox1 (.bin(x[48:43]), .bout(s[32:29]));
  sbox2 u_sbox2 (.bin(x[42:37]), .bout(s[28:25]));
  sbox3 u_sbox3 (.bin(x[36:31]), .bout(s[24:21]));
  sbox4 u_sbox4 (.bin(x[30:25]), .bout(s[20:17]));
  sbox5 u_sbox5 (.bin(x[24:19]), .bout(s[16:13]));
  sbox6 u_sbox6 (.bin(x[18:13]), .bout(s[12:9]));
  sbox7 u_sbox7 (.bin(x[12:7]),  .bout(s[8:5]));
  sbox8 u_sbox8 (.bin(x[6:1]),   .bout(s[4:1]));

  for (genvar j = 0; j < HALF_W; j++) begin : g_p
    assign f[HALF_W-j] = s[HALF_W+1-P_T[j]];
  end

endmodule

// File: rtl/sbox1.sv
// DES S-box 1: Bin[6:1] -> Bout[4:1].
module sbox1
  import des_pkg::*;
(
  input  logic [6:1] bin,
  output logic [4:1] bout
);
  localparam logic [255:0] TABLE =
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  assign bout = sbox_lookup(TABLE, bin);
endmodule

// File: rtl/sbox2.sv
// DES S-box 2: Bin[6:1] -> Bout[4:1].
module sbox2
  import des_pkg::*;
(
  input  logic [6:1] bin,
  output logic [4:1] bout
);
  localparam logic [255:0] TABLE =
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  assign bout = sbox_lookup(TABLE, bin);
endmodule

// File: rtl/sbox3.sv
// DES S-box 3: Bin[6:1] -> Bout[4:1].
module sbox3
  import des_pkg::*;
(
  input  logic [6:1] bin,
  output logic [4:1] bout
);
  localparam logic [255:0] TABLE =
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  assign bout = sbox_lookup(TABLE, bin);
endmodule

// File: rtl/sbox4.sv
// DES S-box 4: Bin[6:1] -> Bout[4:1].
module sbox4
  import des_pkg::*;
(
  input  logic [6:1] bin,
  output logic [4:1] bout
);
  localparam logic [255:0] TABLE =
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  assign bout = sbox_lookup(TABLE, bin);
endmodule

// File: rtl/sbox5.sv
// DES S-box 5: Bin[6:1] -> Bout[4:1].
module sbox5
  import des_pkg::*;
(
  input  logic [6:1] bin,
  output logic [4:1] bout
);
  localparam logic [255:0] TABLE =
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  assign bout = sbox_lookup(TABLE, bin);
endmodule

// File: rtl/sbox6.sv
// DES S-box 6: Bin[6:1] -> Bout[4:1].
module sbox6
  import des_pkg::*;
(
  input  logic [6:1] bin,
  output logic [4:1] bout
);
  localparam logic [255:0] TABLE =
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  assign bout = sbox_lookup(TABLE, bin);
endmodule

// File: rtl/sbox7.sv
// DES S-box 7: Bin[6:1] -> Bout[4:1].
module sbox7
  import des_pkg::*;
(
  input  logic [6:1] bin,
  output logic [4:1] bout
);
  localparam logic [255:0] TABLE =
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  assign bout = sbox_lookup(TABLE, bin);
endmodule

// File: rtl/sbox8.sv
// DES S-box 8: Bin[6:1] -> Bout[4:1].
module sbox8
  import des_pkg::*;
(
  input  logic [6:1] bin,
  output logic [4:1] bout
);
  localparam logic [255:0] TABLE =
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
  assign bout = sbox_lookup(TABLE, bin);
endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock, key schedule
// run backwards by rotating C/D right after each round.
// DES_ENCRYPT_MODE_EN: when defined, adds mode_enc; mode_enc=1 selects the
// forward (left-rotate) key schedule so the same datapath encrypts.
module des_decrypt_core
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W:1]   ciphertext,
  input  logic [BLOCK_W:1]   key,
`ifdef DES_ENCRYPT_MODE_EN
  input  logic               mode_enc,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W:1]   plaintext,
  output logic               busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  des_state_e        state_q, state_d;
  logic [HALF_W:1]   l_q, l_d, r_q, r_d;
  logic [KEY56_W:1]  cd_q, cd_d;
  logic [3:0]        rnd_q, rnd_d;
  logic              out_valid_q, out_valid_d;
  logic [BLOCK_W:1]  plaintext_q, plaintext_d;
`ifdef DES_ENCRYPT_MODE_EN
  logic              mode_q, mode_d;
  logic [KEY56_W:1]  cd_rotl;
`endif

  logic [BLOCK_W:1]  ip_blk;
  logic [KEY56_W:1]  pc1_key;
  logic [KEY56_W:1]  cd_use, cd_next;
  logic [SUBKEY_W:1] subkey;
  logic [HALF_W:1]   f_out, r_new;
  logic [BLOCK_W:1]  fp_in, fp_blk;
  logic [3:0]        shift_idx;
  logic              parity_unused;

  // Parity bits (DES bits 8,16,..,64) are dropped by PC1.
  assign parity_unused = ^{key[57], key[49], key[41], key[33],
                           key[25], key[17], key[9],  key[1]};

  for (genvar j = 0; j < BLOCK_W; j++) begin : g_ip
    assign ip_blk[BLOCK_W-j] = ciphertext[BLOCK_W+1-IP_T[j]];
  end

  for (genvar j = 0; j < KEY56_W; j++) begin : g_pc1
    assign pc1_key[KEY56_W-j] = key[BLOCK_W+1-PC1_T[j]];
  end

  // Key schedule: subkey from current C/D, then rotate back one schedule step.
  always_comb begin
    shift_idx = LAST_RND - rnd_q;
    cd_use    = cd_q;
    cd_next   = {rotr28(cd_q[56:29], SHIFT[shift_idx]),
                 rotr28(cd_q[28:1],  SHIFT[shift_idx])};
`ifdef DES_ENCRYPT_MODE_EN
    cd_rotl   = {rotl28(cd_q[56:29], SHIFT[rnd_q]),
                 rotl28(cd_q[28:1],  SHIFT[rnd_q])};
    if (mode_q) begin
      cd_use  = cd_rotl;
      cd_next = cd_rotl;
    end
`endif
  end

  for (genvar j = 0; j < SUBKEY_W; j++) begin : g_pc2
    assign subkey[SUBKEY_W-j] = cd_use[KEY56_W+1-PC2_T[j]];
  end

  des_f_func u_f_func (
    .r (r_q),
    .k (subkey),
    .f (f_out)
  );

  assign r_new = l_q ^ f_out;

  // Final round output is {R16, L16}: the last Feistel swap is undone.
  assign fp_in = {r_new, r_q};

  for (genvar j = 0; j < BLOCK_W; j++) begin : g_fp
    assign fp_blk[BLOCK_W-j] = fp_in[BLOCK_W+1-FP_T[j]];
  end

  // FSM next-state and register updates: accept, iterate rounds, hold result.
  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    cd_d        = cd_q;
    rnd_d       = rnd_q;
    out_valid_d = out_valid_q;
    plaintext_d = plaintext_q;
`ifdef DES_ENCRYPT_MODE_EN
    mode_d      = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          l_d     = ip_blk[64:33];
          r_d     = ip_blk[32:1];
          cd_d    = pc1_key;
          rnd_d   = '0;
          state_d = ROUND;
`ifdef DES_ENCRYPT_MODE_EN
          mode_d  = mode_enc;
`endif
        end
      end
      ROUND: begin
        l_d   = r_q;
        r_d   = r_new;
        cd_d  = cd_next;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          plaintext_d = fp_blk;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; a reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      cd_q        <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      plaintext_q <= '0;
`ifdef DES_ENCRYPT_MODE_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      cd_q        <= cd_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      plaintext_q <= plaintext_d;
`ifdef DES_ENCRYPT_MODE_EN
      mode_q      <= mode_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign plaintext = plaintext_q;

endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed-vector bench for des_decrypt_core using published DES vectors.
module tb_des_decrypt_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [64:1] ciphertext;
  logic [64:1] key;
  logic        out_valid;
  logic        out_ready;
  logic [64:1] plaintext;
  logic        busy;
`ifdef DES_ENCRYPT_MODE_EN
  logic        mode_enc;
`endif

  int n_vec;
  int n_err;

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2  = 64'h0000000000000000;
  localparam logic [63:0] P2  = 64'h8787878787878787;

  des_decrypt_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
`ifdef DES_ENCRYPT_MODE_EN
    .mode_enc   (mode_enc),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one block, then count edges until out_valid; optionally churn inputs meanwhile.
  task automatic run_block(input logic [63:0] ct, input logic [63:0] k, input logic enc,
                           input bit scramble, output logic [63:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid   = 1'b1;
    ciphertext = ct;
    key        = k;
`ifdef DES_ENCRYPT_MODE_EN
    mode_enc   = enc;
`else
    if (enc) $display("note: encrypt request without encrypt build");
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        ciphertext = {$urandom, $urandom};
        key        = {$urandom, $urandom};
        in_valid   = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    res = plaintext;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov"},  64'(out_valid), 64'd0);
    chk({tag, "_rdy"}, 64'(in_ready),  64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int          lat;
    bit          seen;
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    key        = '0;
`ifdef DES_ENCRYPT_MODE_EN
    mode_enc   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_plaintext", plaintext,      64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Classic vector and latency
    run_block(C1, K1, 1'b0, 1'b0, res, lat);
    chk("t1_pt",  res, P1);
    chk("t1_lat", 64'(lat), 64'd16);
    drain("t1");

    // Second key, all-zero ciphertext
    run_block(C2, K2, 1'b0, 1'b0, res, lat);
    chk("t2_pt",  res, P2);
    chk("t2_lat", 64'(lat), 64'd16);
    drain("t2");

    // Backpressure: hold result for 10 cycles while a new block is offered
    run_block(C1, K1, 1'b0, 1'b0, res, lat);
    chk("bp_pt0", res, P1);
    for (int i = 0; i < 10; i++) begin
      in_valid   = 1'b1;
      ciphertext = C2;
      key        = K2;
      @(posedge clk); #1;
      chk("bp_hold_pt", plaintext, P1);
    end
    chk("bp_in_ready",  64'(in_ready),  64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_busy",      64'(busy),      64'd1);
    in_valid = 1'b0;
    drain("bp");
    run_block(C2, K2, 1'b0, 1'b0, res, lat);
    chk("bp_next_pt",  res, P2);
    chk("bp_next_lat", 64'(lat), 64'd16);
    drain("bp_next");

    // Input bus churned while rounds run
    run_block(C1, K1, 1'b0, 1'b1, res, lat);
    chk("scr_pt",  res, P1);
    chk("scr_lat", 64'(lat), 64'd16);
    drain("scr");

    // Reset in the middle of a block
    in_valid   = 1'b1;
    ciphertext = C1;
    key        = K1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_ov",   64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy),      64'd0);
    chk("mid_rst_rdy",  64'(in_ready),  64'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_ov",  64'(seen),     64'd0);
    chk("mid_rst_rdy2",   64'(in_ready), 64'd1);
    run_block(C1, K1, 1'b0, 1'b0, res, lat);
    chk("post_rst_pt",  res, P1);
    chk("post_rst_lat", 64'(lat), 64'd16);
    drain("post_rst");

`ifdef DES_ENCRYPT_MODE_EN
    // Encrypt, then decrypt the result back
    run_block(P1, K1, 1'b1, 1'b0, res, lat);
    chk("enc_ct",  res, C1);
    chk("enc_lat", 64'(lat), 64'd16);
    drain("enc");
    run_block(res, K1, 1'b0, 1'b0, res, lat);
    chk("enc_dec_pt", res, P1);
    drain("enc_dec");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
